// File: rtl/if_pkg.sv
// Shared definitions for the RV32I instruction-fetch stage: run-state encodings,
// the canonical NOP and the default reset PC.
package if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } run_state_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_hold_buf.sv
// One-entry hold buffer that absorbs load-use stalls, plus the ID output mux
// selecting between the held instruction and fresh instruction-memory data.
module if_hold_buf
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_stall_ld,
  input  logic        i_jmp_do,
  input  logic        i_kill,
  input  logic        i_rdata_valid,
  input  logic [31:0] i_imem_rdata,
  input  logic [29:0] i_pc_dly,
  output logic [31:0] o_inst_id,
  output logic [29:0] o_pc_id,
  output logic        o_inst_valid_id
);

  logic        r_hold_valid;
  logic [31:0] r_hold_inst;
  logic [29:0] r_hold_pc;
  logic        w_valid;
  logic        w_capture;

  assign w_valid         = (r_hold_valid | i_rdata_valid) & ~i_kill;
  assign o_inst_valid_id = w_valid;
  assign o_pc_id         = r_hold_valid ? r_hold_pc : i_pc_dly;
  assign o_inst_id       = !w_valid     ? NOP_INST
                         : r_hold_valid ? r_hold_inst
                         :                i_imem_rdata;

  // Only a live in-path instruction is worth parking; a killed slot is refetched anyway.
  assign w_capture = i_stall_ld & ~r_hold_valid & w_valid;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_inst  <= NOP_INST;
      r_hold_pc    <= '0;
    end else begin
      if (i_jmp_do || !i_stall_ld) begin
        r_hold_valid <= 1'b0;
      end else if (w_capture) begin
        r_hold_valid <= 1'b1;
      end
      if (w_capture) begin
        r_hold_inst <= o_inst_id;
        r_hold_pc   <= o_pc_id;
      end
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: run/halt FSM, PC register, imem read address and
// redirect/purge handling. Optional misaligned-redirect flag: IF_MISALIGN_TRAP_EN.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_start,
  input  logic               cpu_stop,
  input  logic               stall_ld,
  input  logic               jmp_do,
  input  logic [31:0]        jmp_adr,
  output logic [IMEM_AW-1:0] imem_radr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst_id,
  output logic [29:0]        pc_id,
  output logic               inst_valid_id,
  output logic               jmp_purge_id,
`ifdef IF_MISALIGN_TRAP_EN
  output logic               inst_misalign_id,
`endif
  output logic [1:0]         run_state
);

  run_state_e  r_state;
  run_state_e  w_state_nxt;
  logic [29:0] r_pc_fetch;
  logic [29:0] r_pc_dly;
  logic        r_rdata_valid;
  logic        r_purge;
  logic        w_run;
  logic        w_kill;

  assign w_run     = (r_state == ST_RUN);
  assign run_state = r_state;
  assign imem_radr = r_pc_fetch[IMEM_AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (cpu_start)             w_state_nxt = ST_RUN;
      ST_RUN:  if (cpu_stop && !stall_ld) w_state_nxt = ST_HALT;
      ST_HALT: if (cpu_start)             w_state_nxt = ST_RUN;
      default:                            w_state_nxt = ST_IDLE;
    endcase
  end

  // pc_dly tracks the address whose data the synchronous imem returns next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_fetch    <= RESET_PC[31:2];
      r_pc_dly      <= '0;
      r_rdata_valid <= 1'b0;
      r_purge       <= 1'b0;
    end else begin
      r_purge       <= jmp_do;
      r_rdata_valid <= w_run & ~stall_ld & ~jmp_do & ~cpu_stop;
      if (w_run) r_pc_dly <= r_pc_fetch;
      if (jmp_do) begin
        r_pc_fetch <= jmp_adr[31:2];
      end else if (w_run && !stall_ld && !cpu_stop) begin
        r_pc_fetch <= r_pc_fetch + 30'd1;
      end
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_misalign <= 1'b0;
    else if (jmp_do) r_misalign <= |jmp_adr[1:0];
  end

  assign inst_misalign_id = r_misalign;
  assign w_kill           = jmp_do | r_purge | r_misalign;
`else
  logic w_unused_jmp_lsb;
  assign w_unused_jmp_lsb = ^jmp_adr[1:0];
  assign w_kill           = jmp_do | r_purge;
`endif

  assign jmp_purge_id = r_purge | jmp_do;

  if_hold_buf u_hold_buf (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_stall_ld      (stall_ld),
    .i_jmp_do        (jmp_do),
    .i_kill          (w_kill),
    .i_rdata_valid   (r_rdata_valid),
    .i_imem_rdata    (imem_rdata),
    .i_pc_dly        (r_pc_dly),
    .o_inst_id       (inst_id),
    .o_pc_id         (pc_id),
    .o_inst_valid_id (inst_valid_id)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: start, stall, redirect, stall+redirect,
// stop/resume, async reset, and (with IF_MISALIGN_TRAP_EN) misaligned redirect.
module tb_if_fetch_stage;
  import if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_start = 1'b0;
  logic        cpu_stop = 1'b0;
  logic        stall_ld = 1'b0;
  logic        jmp_do = 1'b0;
  logic [31:0] jmp_adr = '0;
  logic [11:0] imem_radr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic [31:0] inst_id;
  logic [29:0] pc_id;
  logic        inst_valid_id;
  logic        jmp_purge_id;
  logic [1:0]  run_state;
`ifdef IF_MISALIGN_TRAP_EN
  logic        inst_misalign_id;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_AW(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_start     (cpu_start),
    .cpu_stop      (cpu_stop),
    .stall_ld      (stall_ld),
    .jmp_do        (jmp_do),
    .jmp_adr       (jmp_adr),
    .imem_radr     (imem_radr),
    .imem_rdata    (imem_rdata),
    .inst_id       (inst_id),
    .pc_id         (pc_id),
    .inst_valid_id (inst_valid_id),
    .jmp_purge_id  (jmp_purge_id),
`ifdef IF_MISALIGN_TRAP_EN
    .inst_misalign_id (inst_misalign_id),
`endif
    .run_state     (run_state)
  );

  always #5 clk = ~clk;

  // Synchronous-read instruction memory; each word encodes its own address.
  // NOTE: a memory model like this is deliberately not reset; its contents are
  // a pure function of the address.
  always @(posedge clk) imem_rdata <= {8'hA5, 12'h000, imem_radr};

  function automatic logic [31:0] inst_of(input logic [29:0] p);
    return {8'hA5, 12'h000, p[11:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slot(input string tag, input logic v, input logic [29:0] p, input logic pg);
    check({tag, ".valid"}, {31'b0, inst_valid_id}, {31'b0, v});
    check({tag, ".purge"}, {31'b0, jmp_purge_id}, {31'b0, pg});
    if (v) begin
      check({tag, ".pc"}, {2'b00, pc_id}, {2'b00, p});
      check({tag, ".inst"}, inst_id, inst_of(p));
    end else begin
      check({tag, ".nop"}, inst_id, NOP_INST);
    end
  endtask

  task automatic state_is(input string tag, input logic [1:0] s);
    check({tag, ".state"}, {30'b0, run_state}, {30'b0, s});
  endtask

  task automatic radr_is(input string tag, input logic [11:0] a);
    check({tag, ".radr"}, {20'b0, imem_radr}, {20'b0, a});
  endtask

  // Advance one clock, drive this cycle's inputs, let combinational outputs settle.
  task automatic cyc(input logic st, input logic sp, input logic sl,
                     input logic jd, input logic [31:0] ja);
    @(posedge clk);
    #1;
    cpu_start = st;
    cpu_stop  = sp;
    stall_ld  = sl;
    jmp_do    = jd;
    jmp_adr   = ja;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #3;
    slot("reset", 1'b0, 30'h0, 1'b0);
    state_is("reset", 2'b00);
    radr_is("reset", 12'h000);

    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Start: state goes RUN after the start cycle, first valid two cycles later.
    cyc(0, 0, 0, 0, 32'h0);
    slot("idle", 1'b0, 30'h0, 1'b0);
    cyc(1, 0, 0, 0, 32'h0);
    state_is("start_cyc", 2'b00);
    cyc(0, 0, 0, 0, 32'h0);
    state_is("run1", 2'b01);
    radr_is("run1", 12'h000);
    slot("run1", 1'b0, 30'h0, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("first", 1'b1, 30'h0, 1'b0);
    radr_is("first", 12'h001);
    for (int p = 1; p <= 4; p++) begin
      cyc(0, 0, 0, 0, 32'h0);
      slot("seq", 1'b1, 30'(p), 1'b0);
    end

    // Three-cycle load-use stall on pc 5: held for four cycles, then 6, 7.
    cyc(0, 0, 1, 0, 32'h0);
    slot("stall1", 1'b1, 30'h5, 1'b0);
    cyc(0, 0, 1, 0, 32'h0);
    slot("stall2", 1'b1, 30'h5, 1'b0);
    radr_is("stall2", 12'h006);
    cyc(0, 0, 1, 0, 32'h0);
    slot("stall3", 1'b1, 30'h5, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("stall4", 1'b1, 30'h5, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("post_stall6", 1'b1, 30'h6, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("post_stall7", 1'b1, 30'h7, 1'b0);

    // Redirect while pc 8 sits in ID: two purged slots, then target 0x40.
    cyc(0, 0, 0, 1, 32'h0000_0100);
    slot("jmp0", 1'b0, 30'h0, 1'b1);
    cyc(0, 0, 0, 0, 32'h0);
    slot("jmp1", 1'b0, 30'h0, 1'b1);
    cyc(0, 0, 0, 0, 32'h0);
    slot("jmp_tgt", 1'b1, 30'h40, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("jmp_tgt1", 1'b1, 30'h41, 1'b0);

    // Redirect during a stall with the hold buffer occupied.
    cyc(0, 0, 1, 0, 32'h0);
    slot("hj_stall", 1'b1, 30'h42, 1'b0);
    cyc(0, 0, 1, 1, 32'h0000_0200);
    slot("hj_jmp", 1'b0, 30'h0, 1'b1);
    cyc(0, 0, 0, 0, 32'h0);
    slot("hj_purge", 1'b0, 30'h0, 1'b1);
    cyc(0, 0, 0, 0, 32'h0);
    slot("hj_tgt", 1'b1, 30'h80, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("hj_tgt1", 1'b1, 30'h81, 1'b0);

    // Stop with 0x10 in ID, then resume at 0x11.
    cyc(0, 0, 0, 1, 32'h0000_0040);
    slot("s_jmp", 1'b0, 30'h0, 1'b1);
    cyc(0, 0, 0, 0, 32'h0);
    slot("s_purge", 1'b0, 30'h0, 1'b1);
    cyc(0, 1, 0, 0, 32'h0);
    slot("stop_last", 1'b1, 30'h10, 1'b0);
    state_is("stop_cyc", 2'b01);
    cyc(0, 0, 0, 0, 32'h0);
    state_is("halted", 2'b10);
    slot("halted", 1'b0, 30'h0, 1'b0);
    radr_is("halted", 12'h011);
    cyc(1, 0, 0, 0, 32'h0);
    state_is("resume_cyc", 2'b10);
    cyc(0, 0, 0, 0, 32'h0);
    state_is("resumed", 2'b01);
    slot("resumed", 1'b0, 30'h0, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("resume_first", 1'b1, 30'h11, 1'b0);

    // Start and stop together in RUN: stop wins, 0x12 is consumed.
    cyc(1, 1, 0, 0, 32'h0);
    slot("both", 1'b1, 30'h12, 1'b0);
    cyc(0, 0, 0, 0, 32'h0);
    state_is("both_halt", 2'b10);
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    state_is("both_run", 2'b01);
    cyc(0, 0, 0, 0, 32'h0);
    slot("both_next", 1'b1, 30'h13, 1'b0);

    // Asynchronous reset in the middle of a cycle.
    #1 rst_n = 1'b0;
    #1;
    slot("mid_rst", 1'b0, 30'h0, 1'b0);
    state_is("mid_rst", 2'b00);
    radr_is("mid_rst", 12'h000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc(0, 0, 0, 0, 32'h0);
    slot("after_rst", 1'b0, 30'h0, 1'b0);
    state_is("after_rst", 2'b00);

`ifdef IF_MISALIGN_TRAP_EN
    cyc(1, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("ma_first", 1'b1, 30'h0, 1'b0);
    cyc(0, 0, 0, 1, 32'h0000_0102);
    check("ma_jmp.flag", {31'b0, inst_misalign_id}, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    check("ma_set.flag", {31'b0, inst_misalign_id}, 32'h1);
    slot("ma_set", 1'b0, 30'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 32'h0);
      slot("ma_hold", 1'b0, 30'h0, 1'b0);
      check("ma_hold.flag", {31'b0, inst_misalign_id}, 32'h1);
    end
    cyc(0, 0, 0, 1, 32'h0000_0100);
    check("ma_clrjmp.flag", {31'b0, inst_misalign_id}, 32'h1);
    cyc(0, 0, 0, 0, 32'h0);
    check("ma_clr.flag", {31'b0, inst_misalign_id}, 32'h0);
    cyc(0, 0, 0, 0, 32'h0);
    slot("ma_tgt", 1'b1, 30'h40, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
